sw_event_decoder: RTL and testbench

SW_EVENT_DECODER -- requirements
Module: sw_event_decoder

---
 rtl/sw_event_decoder.sv | 144 ++++++++++++++
 tb/tb_sw_event_decoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sw_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : sw_event_decoder
//  Brief    : Turns debounced press/release pulses into click, double-click
//             and long-press events, delivered through a one-entry
//             valid/ready slot with a sticky overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
module sw_event_decoder #(
  parameter int CNT_BITS = 26,
  parameter int LONG_CNT = 50_000_000,
  parameter int DBL_CNT  = 15_000_000
) (
  input  logic       clk50m,
  input  logic       rst,
  input  logic       sw_hi,
  input  logic       sw_lo,
  output logic       ev_valid,
  output logic [1:0] ev_code,
  input  logic       ev_ready,
  output logic       ev_overflow,
  output logic       held
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS1 = 3'd1,
    S_WAIT2  = 3'd2,
    S_PRESS2 = 3'd3,
    S_LONG   = 3'd4
  } state_t;

  localparam logic [1:0] C_EV_NONE   = 2'b00;
  localparam logic [1:0] C_EV_CLICK  = 2'b01;
  localparam logic [1:0] C_EV_DOUBLE = 2'b10;
  localparam logic [1:0] C_EV_LONG   = 2'b11;

  // Terminal counts: the timeout fires on the cycle the counter sits at N-1.
  localparam logic [CNT_BITS-1:0] C_LONG_LAST = CNT_BITS'(LONG_CNT - 1);
  localparam logic [CNT_BITS-1:0] C_DBL_LAST  = CNT_BITS'(DBL_CNT - 1);
  localparam logic [CNT_BITS-1:0] C_ONE       = CNT_BITS'(1);

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]          w_issue;
  logic                w_press;
  logic                w_release;

  logic                ev_valid_q;
  logic [1:0]          ev_code_q;
  logic                ev_overflow_q;

  // Simultaneous press and release pulses are contradictory; treat as no input.
  assign w_press   = sw_hi & ~sw_lo;
  assign w_release = sw_lo & ~sw_hi;

  // State and timing counter register.
  always_ff @(posedge clk50m) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; input pulses take priority over the timeouts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_issue = C_EV_NONE;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (w_press) state_d = S_PRESS1;
      end
      S_PRESS1: begin
        cnt_d = cnt_q + C_ONE;
        if (w_release) begin
          state_d = S_WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == C_LONG_LAST) begin
          state_d = S_LONG;
          cnt_d   = '0;
          w_issue = C_EV_LONG;
        end
      end
      S_WAIT2: begin
        cnt_d = cnt_q + C_ONE;
        if (w_press) begin
          state_d = S_PRESS2;
          cnt_d   = '0;
        end else if (cnt_q == C_DBL_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          w_issue = C_EV_CLICK;
        end
      end
      S_PRESS2: begin
        cnt_d = '0;
        if (w_release) begin
          state_d = S_IDLE;
          w_issue = C_EV_DOUBLE;
        end
      end
      S_LONG: begin
        cnt_d = '0;
        if (w_release) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // One-entry event slot: a new event is dropped only if the old one stays unread.
  always_ff @(posedge clk50m) begin
    if (rst) begin
      ev_valid_q    <= 1'b0;
      ev_code_q     <= C_EV_NONE;
      ev_overflow_q <= 1'b0;
    end else if (w_issue != C_EV_NONE) begin
      if (ev_valid_q && !ev_ready) begin
        ev_overflow_q <= 1'b1;
      end else begin
        ev_valid_q <= 1'b1;
        ev_code_q  <= w_issue;
      end
    end else if (ev_valid_q && ev_ready) begin
      ev_valid_q <= 1'b0;
      ev_code_q  <= C_EV_NONE;
    end
  end

  assign ev_valid    = ev_valid_q;
  assign ev_code     = ev_code_q;
  assign ev_overflow = ev_overflow_q;
  assign held        = (state_q == S_PRESS1) || (state_q == S_PRESS2) ||
                       (state_q == S_LONG);

endmodule
`default_nettype wire

// File: tb/tb_sw_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sw_event_decoder
//  Brief    : Self-checking bench for sw_event_decoder using a timestamp-based
//             reference model and a queue for the event slot.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sw_event_decoder;

  localparam int CB = 4;
  localparam int LC = 10;
  localparam int DC = 6;

  // Model phases
  localparam int M_IDLE = 0;
  localparam int M_P1   = 1;
  localparam int M_W2   = 2;
  localparam int M_P2   = 3;
  localparam int M_LG   = 4;

  logic       clk50m = 1'b0;
  logic       rst = 1'b0;
  logic       sw_hi = 1'b0;
  logic       sw_lo = 1'b0;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [1:0] ev_code;
  logic       ev_overflow;
  logic       held;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: phase, edge index of the last phase entry, slot queue.
  int mode = M_IDLE;
  int mark = 0;
  int cyc  = 0;
  int slot[$];
  bit ovf  = 1'b0;

  sw_event_decoder #(
    .CNT_BITS(CB),
    .LONG_CNT(LC),
    .DBL_CNT (DC)
  ) dut (
    .clk50m     (clk50m),
    .rst        (rst),
    .sw_hi      (sw_hi),
    .sw_lo      (sw_lo),
    .ev_valid   (ev_valid),
    .ev_code    (ev_code),
    .ev_ready   (ev_ready),
    .ev_overflow(ev_overflow),
    .held       (held)
  );

  always #5 clk50m = ~clk50m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one rising edge with the inputs sampled there.
  task automatic model_edge(input bit hi, input bit lo, input bit rdy, input bit r);
    int issue;
    bit h;
    bit l;
    int el;
    if (r) begin
      mode = M_IDLE;
      slot.delete();
      ovf  = 1'b0;
    end else begin
      issue = 0;
      h  = hi && !lo;
      l  = lo && !hi;
      el = cyc - mark;
      case (mode)
        M_IDLE: if (h) begin mode = M_P1; mark = cyc; end
        M_P1: begin
          if (l) begin mode = M_W2; mark = cyc; end
          else if (el == LC) begin mode = M_LG; issue = 3; end
        end
        M_W2: begin
          if (h) mode = M_P2;
          else if (el == DC) begin mode = M_IDLE; issue = 1; end
        end
        M_P2: if (l) begin mode = M_IDLE; issue = 2; end
        M_LG: if (l) mode = M_IDLE;
        default: mode = M_IDLE;
      endcase
      if (rdy && slot.size() != 0) void'(slot.pop_front());
      if (issue != 0) begin
        if (slot.size() == 0) slot.push_back(issue);
        else ovf = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic compare_outputs();
    int ev;
    int ec;
    int eh;
    ev = (slot.size() != 0) ? 1 : 0;
    ec = (slot.size() != 0) ? slot[0] : 0;
    eh = (mode == M_P1 || mode == M_P2 || mode == M_LG) ? 1 : 0;
    check("ev_valid", 32'(ev_valid), ev);
    check("ev_code", 32'(ev_code), ec);
    check("ev_overflow", 32'(ev_overflow), 32'(ovf));
    check("held", 32'(held), eh);
  endtask

  // Drive one cycle, then compare a nanosecond after the edge.
  task automatic step(input bit hi, input bit lo, input bit rdy, input bit r);
    sw_hi    = hi;
    sw_lo    = lo;
    ev_ready = rdy;
    rst      = r;
    @(posedge clk50m);
    model_edge(hi, lo, rdy, r);
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    bit rdy_hi;
    bit hi;
    bit lo;
    bit r;
    bit rdy;

    // Reset: even with junk inputs present the design must come up clean.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("reset_valid", 32'(ev_valid), 0);
    check("reset_held", 32'(held), 0);
    idle(3, 1'b1);

    // Single click with a ready consumer.
    step(1'b1, 1'b0, 1'b1, 1'b0);         // edge 0
    idle(2, 1'b1);                         // edges 1..2
    check("click_held", 32'(held), 1);
    step(1'b0, 1'b1, 1'b1, 1'b0);         // edge 3
    idle(5, 1'b1);                         // edges 4..8
    check("click_early", 32'(ev_valid), 0);
    idle(1, 1'b1);                         // edge 9
    check("click_valid", 32'(ev_valid), 1);
    check("click_code", 32'(ev_code), 1);
    idle(1, 1'b1);                         // edge 10
    check("click_once", 32'(ev_valid), 0);
    idle(3, 1'b1);

    // Double click.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("dbl_code", 32'(ev_code), 2);
    idle(10, 1'b1);

    // Long press: event held until accepted, no event on release.
    step(1'b1, 1'b0, 1'b0, 1'b0);         // edge 0
    idle(9, 1'b0);                         // edges 1..9
    check("long_early", 32'(ev_valid), 0);
    idle(1, 1'b0);                         // edge 10
    check("long_code", 32'(ev_code), 3);
    idle(9, 1'b1);                         // edges 11..19
    step(1'b0, 1'b1, 1'b1, 1'b0);         // edge 20
    check("long_release_held", 32'(held), 0);
    idle(3, 1'b1);
    check("long_release_ev", 32'(ev_valid), 0);

    // Overflow: two clicks with nobody reading.
    step(1'b1, 1'b0, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0, 1'b0); idle(10, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0, 1'b0); idle(10, 1'b0);
    check("ovf_code", 32'(ev_code), 1);
    check("ovf_flag", 32'(ev_overflow), 1);
    idle(2, 1'b1);
    check("ovf_sticky", 32'(ev_overflow), 1);

    // Boundary: press wins on the double-click timeout cycle.
    step(1'b1, 1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(5, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("bnd_w2_held", 32'(held), 1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(8, 1'b1);
    // Boundary: release wins on the long-press timeout cycle.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(9, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("bnd_p1_noevt", 32'(ev_valid), 0);
    idle(8, 1'b1);
    // Simultaneous pulses are no input.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("both_idle", 32'(held), 0);
    idle(2, 1'b1);

    // Reset mid-press with a pending event.
    step(1'b1, 1'b0, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0, 1'b0); idle(8, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(7, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("rst_mid_valid", 32'(ev_valid), 0);
    check("rst_mid_held", 32'(held), 0);
    check("rst_mid_ovf", 32'(ev_overflow), 0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(12, 1'b1);
    check("rst_mid_noevt", 32'(ev_valid), 0);

    // Randomized traffic against the model.
    rdy_hi = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ((i % 64) == 0) rdy_hi = ($urandom_range(0, 1) == 1);
      r   = ($urandom_range(0, 299) == 0);
      hi  = ($urandom_range(0, 5) == 0);
      lo  = ($urandom_range(0, 5) == 0);
      rdy = rdy_hi ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      step(hi, lo, rdy, r);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
